// File: rtl/ysyx_22041752_wbu_pkg.sv
// Shared definitions for the ysyx_22041752 write-back stage:
// bus widths, bit-field offsets of the MS->WS and forward buses,
// the MS->WS payload struct and a forward-bus packing helper.
package ysyx_22041752_wbu_pkg;

    // Bus and field widths shared with the rest of the core
    localparam int MS_TO_WS_BUS_WD = 134;
    localparam int FORWARD_BUS_WD  = 71;
    localparam int RF_ADDR_WD      = 5;
    localparam int RF_DATA_WD      = 64;
    localparam int PC_WD           = 64;

    // MS->WS bus field offsets: {rf_we, rd, result, pc}
    localparam int MS_PC_LSB     = 0;
    localparam int MS_RESULT_LSB = 64;
    localparam int MS_RD_LSB     = 128;
    localparam int MS_RF_WE_BIT  = 133;

    // Forward bus field offsets: {load_miss, fwd_valid, result, rd}
    localparam int FWD_RD_LSB        = 0;
    localparam int FWD_RESULT_LSB    = 5;
    localparam int FWD_VALID_BIT     = 69;
    localparam int FWD_LOAD_MISS_BIT = 70;

    // Packed view of the MS->WS bus; field order matches the offsets above
    typedef struct packed {
        logic                  rf_we;
        logic [RF_ADDR_WD-1:0] rd;
        logic [RF_DATA_WD-1:0] result;
        logic [PC_WD-1:0]      pc;
    } ms_to_ws_t;

    // WS never holds a pending load, so load_miss is always 0
    function automatic logic [FORWARD_BUS_WD-1:0] pack_forward(
        input logic                  fwd_valid,
        input logic [RF_ADDR_WD-1:0] rd,
        input logic [RF_DATA_WD-1:0] result
    );
        return {1'b0, fwd_valid, result, rd};
    endfunction

endpackage

// File: rtl/ysyx_22041752_trace_fifo.sv
// Commit-trace FIFO for the write-back stage.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// When empty, head_data holds the most recently popped entry (0 after reset).
module ysyx_22041752_trace_fifo
    import ysyx_22041752_wbu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 134
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] last_q, last_d;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next-state for pointers, occupancy and the last-read holding register
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        last_d  = last_q;
        if (do_push) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rptr_d = rptr_q + PTR_ONE;
            last_d = mem_q[rptr_q];
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_ONE;
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Control state; reset drops all queued entries
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            last_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    // Storage array; contents are meaningful only between the pointers
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= push_data;
        end
    end

    assign head_data = empty ? last_q : mem_q[rptr_q];

endmodule

// File: rtl/ysyx_22041752_wbu.sv
// Write-back stage of the ysyx_22041752 core.
// Latches the MS result bus, drives the register-file write port, the
// write-back forward bus, a retire pulse/PC and the retired-instruction
// counter. Defining YSYX_22041752_COMMIT_TRACE_EN adds a commit-trace FIFO
// whose full condition back-pressures WS; otherwise WS never stalls.
module ysyx_22041752_wbu
    import ysyx_22041752_wbu_pkg::*;
#(
    parameter int TRACE_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ms_to_ws_valid,
    input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic                       ws_allowin,
    output logic                       rf_we,
    output logic [RF_ADDR_WD-1:0]      rf_waddr,
    output logic [RF_DATA_WD-1:0]      rf_wdata,
    output logic [FORWARD_BUS_WD-1:0]  ws_forward_bus,
    output logic                       ws_retire,
    output logic [PC_WD-1:0]           ws_pc,
    output logic [63:0]                instret
`ifdef YSYX_22041752_COMMIT_TRACE_EN
    ,
    output logic                       trace_valid,
    input  logic                       trace_ready,
    output logic                       trace_we,
    output logic [RF_ADDR_WD-1:0]      trace_rd,
    output logic [RF_DATA_WD-1:0]      trace_wdata,
    output logic [PC_WD-1:0]           trace_pc
`endif
);

    // Reject unusable trace depths at elaboration time
    if (TRACE_DEPTH < 2 || (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0) begin : g_depth_check
        $error("TRACE_DEPTH must be a power of two and at least 2");
    end

    ms_to_ws_t   ms_bus;
    ms_to_ws_t   ws_bus_q, ws_bus_d;
    logic        ws_valid_q, ws_valid_d;
    logic [63:0] instret_q, instret_d;
    logic        ws_ready_go;
    logic        retire;
    logic        rd_nonzero;

    assign ms_bus = ms_to_ws_bus;

`ifdef YSYX_22041752_COMMIT_TRACE_EN
    logic      fifo_full;
    logic      fifo_empty;
    ms_to_ws_t fifo_head;

    ysyx_22041752_trace_fifo #(
        .DEPTH (TRACE_DEPTH),
        .WIDTH (MS_TO_WS_BUS_WD)
    ) u_trace_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (retire),
        .push_data (ws_bus_q),
        .pop       (trace_valid && trace_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (fifo_head)
    );

    // Registered full only: a same-cycle pop does not reopen WS
    assign ws_ready_go = !fifo_full;
    assign trace_valid = !fifo_empty;
    assign trace_we    = fifo_head.rf_we;
    assign trace_rd    = fifo_head.rd;
    assign trace_wdata = fifo_head.result;
    assign trace_pc    = fifo_head.pc;
`else
    assign ws_ready_go = 1'b1;
`endif

    assign ws_allowin = !ws_valid_q || ws_ready_go;
    assign retire     = ws_valid_q && ws_ready_go;
    assign rd_nonzero = (ws_bus_q.rd != '0);

    // Pipeline handshake, bus capture and retire counting
    always_comb begin
        ws_valid_d = ws_valid_q;
        ws_bus_d   = ws_bus_q;
        instret_d  = instret_q;
        if (ws_allowin) begin
            ws_valid_d = ms_to_ws_valid;
        end
        if (ms_to_ws_valid && ws_allowin) begin
            ws_bus_d = ms_bus;
        end
        if (retire) begin
            instret_d = instret_q + 64'd1;
        end
    end

    // WS state; reset discards any in-flight instruction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ws_valid_q <= 1'b0;
            ws_bus_q   <= '0;
            instret_q  <= '0;
        end else begin
            ws_valid_q <= ws_valid_d;
            ws_bus_q   <= ws_bus_d;
            instret_q  <= instret_d;
        end
    end

    // x0 is never written and never forwarded
    assign rf_we          = retire && ws_bus_q.rf_we && rd_nonzero;
    assign rf_waddr       = ws_bus_q.rd;
    assign rf_wdata       = ws_bus_q.result;
    assign ws_forward_bus = pack_forward(ws_valid_q && ws_bus_q.rf_we && rd_nonzero,
                                         ws_bus_q.rd, ws_bus_q.result);
    assign ws_retire      = retire;
    assign ws_pc          = ws_bus_q.pc;
    assign instret        = instret_q;

endmodule
